freq_measure_scheduler: RTL and testbench
=========================================

# freq_measure_scheduler

Sequenced, resource-shared frequency measurement engine for the two analog channels. A single iterative divider and a single shift-add-3 BCD converter are time-multiplexed: CH1 is computed first, then CH2, on each measurement request. The block turns time-cursor positions and the current TimeScale into 5-digit BCD frequency readouts for the on-screen measurement panel. Outputs are registered and hold stable between updates, so display logic never sees partial results.

## Interface
- REFRESH_CYCLES, 1000000, auto-trigger period in Main_CLK cycles. Used only with FREQ_SCHED_AUTO_EN; must be ≥ 80.
- Main_CLK  input  1  system clock; all logic on the rising edge.
- Main_RST_n  input  1  asynchronous, active-low reset.
- Start  input  1  measurement request; sampled only in IDLE.
- TimeScale  input  6  horizontal scale factor.
- CH1_Right_Time_Cursor, CH1_Left_Time_Cursor  input  9 each  CH1 cursor columns.
- CH2_Right_Time_Cursor, CH2_Left_Time_Cursor  input  9 each  CH2 cursor columns.
- CH1_BCD, CH2_BCD  output  20 each  5-digit BCD frequency; reset 0.
- CH1_Ovr, CH2_Ovr  output  1 each  quotient saturated; reset 0.
- CH1_Inval, CH2_Inval  output  1 each  divisor was zero; reset 0.
- Busy  output  1  sequence in progress; reset 0.
- Done  output  1  one-cycle pulse when both channels are updated; reset 0.

## Operation
- States: IDLE, LOAD, DIV, BCD, STORE. The channel select bit `ch` is 0 for CH1 and 1 for CH2.
- IDLE → LOAD on Start=1. Set ch=0 and Busy=1.
- LOAD, 1 cycle:
  - Snapshot TimeScale and the selected channel's cursors.
  - delta = |Right − Left|, 9 bits.
  - divisor = TimeScale × delta, 15 bits unsigned.
  - Load dividend = 1474560 (96 × 15360, 21 bits).
- DIV, 21 cycles: restoring divide, one quotient bit per cycle, MSB first. Quotient register is 21 bits.
- End of DIV, applied before BCD starts:
  - If divisor = 0: binary = 0, Inval = 1, Ovr = 0.
  - Else if quotient > 65535: binary = 65535, Ovr = 1.
  - Else: binary = quotient[15:0].
- BCD, 16 cycles: one shift per cycle.
  - On each of the first 15 shifts, add 3 to every nibble > 4 before shifting.
  - No add-3 on the final shift.
- STORE, 1 cycle: write CHx_BCD, CHx_Ovr and CHx_Inval for the current channel. All three update together.
  - If ch=0: set ch=1 and go to LOAD.
  - If ch=1: pulse Done, clear Busy and go to IDLE.
- Outputs of a channel change only in its STORE cycle. Otherwise they hold their previous values.
- Start while Busy is ignored. It is not queued.
- Cursor or TimeScale changes after a channel's LOAD do not affect that channel's result.
- Reset assertion at any time, including mid-sequence:
  - All outputs and state return to reset values immediately.
  - The state machine goes to IDLE and any partial result is discarded.

## Timing
- Start sampled at edge N. Busy goes high after edge N.
- CH1 STORE at edge N+39. CH1 outputs are valid after edge N+39.
- CH2 STORE at edge N+78. CH2 outputs, Done=1 and Busy=0 are all valid after edge N+78.
- Done deasserts after edge N+79.
- Fixed latency of 78 cycles per sequence, regardless of operand values, zero divisor or saturation.
- Earliest accepted re-Start is at edge N+79.

## Configuration
- FREQ_SCHED_AUTO_EN defined:
  - A free-running counter runs from reset release, counts 0..REFRESH_CYCLES−1 and wraps.
  - The wrap cycle generates an internal start, ORed with Start.
  - The internal start is ignored if Busy, like Start.
- FREQ_SCHED_AUTO_EN undefined:
  - No counter is built. REFRESH_CYCLES is unused.
  - Only Start triggers a sequence.

## Test plan
- Basic measurement, TimeScale=4:
  - Stimulus: CH1 R=100, L=40; CH2 R=80, L=200; Start pulse.
  - Required: after 78 cycles, CH1_BCD=0x06144 and CH2_BCD=0x03072. All Ovr/Inval flags 0. Done is a single one-cycle pulse.
- Saturation, TimeScale=1:
  - Stimulus: CH1 delta=10; CH2 delta=23.
  - Required: CH1_BCD=0x65535 with CH1_Ovr=1 (147456 saturated). CH2_BCD=0x64111 with CH2_Ovr=0.
- Zero divisor:
  - Stimulus: CH1 cursors equal; CH2 with TimeScale=0.
  - Required: CH1_BCD=0 with CH1_Inval=1. CH2_BCD=0 with CH2_Inval=1. Done still arrives at cycle 78.
- Busy and snapshot:
  - Stimulus: Start again at cycle 20 and change the CH1 cursors at cycle 10.
  - Required: exactly one Done, at cycle 78. CH1 result reflects the cursors sampled at LOAD (cycle 1).
- Reset mid-sequence:
  - Stimulus: Main_RST_n low at cycle 50.
  - Required: all outputs 0 and Busy=0 immediately. After release, a new Start yields correct results 78 cycles later.
- FREQ_SCHED_AUTO_EN build:
  - Stimulus: REFRESH_CYCLES=200, Start held 0.
  - Required: Done at cycles 278, 478, 678 after reset release, each 78 cycles after an internal start.

Source files
------------

// File: rtl/freq_measure_scheduler.sv
// Two-channel cursor frequency engine: one shared restoring divider and one shared
// double-dabble converter, CH1 then CH2. Optional auto-refresh: FREQ_SCHED_AUTO_EN.
module freq_measure_scheduler #(
   parameter int REFRESH_CYCLES = 1000000
) (
   input  logic        Main_CLK,
   input  logic        Main_RST_n,
   input  logic        Start,
   input  logic [5:0]  TimeScale,
   input  logic [8:0]  CH1_Right_Time_Cursor,
   input  logic [8:0]  CH1_Left_Time_Cursor,
   input  logic [8:0]  CH2_Right_Time_Cursor,
   input  logic [8:0]  CH2_Left_Time_Cursor,
   output logic [19:0] CH1_BCD,
   output logic [19:0] CH2_BCD,
   output logic        CH1_Ovr,
   output logic        CH2_Ovr,
   output logic        CH1_Inval,
   output logic        CH2_Inval,
   output logic        Busy,
   output logic        Done
);

   localparam logic [20:0] DIVIDEND = 21'd1474560;

   typedef enum logic [2:0] {IDLE, LOAD, DIV, BCD, STORE} state_t;

   state_t      state, next_state;
   logic        ch;
   logic [4:0]  cnt;
   logic [14:0] divisor;
   logic [14:0] rem;
   logic [20:0] dq;
   logic [15:0] bin;
   logic [19:0] bcd;
   logic        ovr, inval;
   logic        start_req;
   logic        load_en, div_en, bcd_en, store_en;

   generate
      if (REFRESH_CYCLES < 80) begin : g_bad_refresh
         $error("REFRESH_CYCLES must be at least 80");
      end
   endgenerate

`ifdef FREQ_SCHED_AUTO_EN
   localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   logic [CW-1:0] refresh_cnt;
   logic          auto_start;

   assign auto_start = (refresh_cnt == CW'(REFRESH_CYCLES - 1));

   always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
      if (!Main_RST_n)     refresh_cnt <= '0;
      else if (auto_start) refresh_cnt <= '0;
      else                 refresh_cnt <= refresh_cnt + 1'b1;
   end

   assign start_req = Start | auto_start;
`else
   assign start_req = Start;
`endif

   always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
      if (!Main_RST_n) state <= IDLE;
      else             state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_req) next_state = LOAD;
         LOAD:    next_state = DIV;
         DIV:     if (cnt == 5'd20) next_state = BCD;
         BCD:     if (cnt == 5'd15) next_state = STORE;
         STORE:   next_state = ch ? IDLE : LOAD;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      load_en  = 1'b0;
      div_en   = 1'b0;
      bcd_en   = 1'b0;
      store_en = 1'b0;
      Busy     = (state != IDLE);
      case (state)
         LOAD:    load_en  = 1'b1;
         DIV:     div_en   = 1'b1;
         BCD:     bcd_en   = 1'b1;
         STORE:   store_en = 1'b1;
         default: ;
      endcase
   end

   // Operand selection and cursor distance for the channel being loaded
   logic [8:0] cur_r, cur_l, delta;
   assign cur_r = ch ? CH2_Right_Time_Cursor : CH1_Right_Time_Cursor;
   assign cur_l = ch ? CH2_Left_Time_Cursor  : CH1_Left_Time_Cursor;
   assign delta = (cur_r >= cur_l) ? (cur_r - cur_l) : (cur_l - cur_r);

   // Restoring step; a successful subtract always fits 15 bits, so modular
   // 15-bit subtraction gives the exact new remainder.
   logic [15:0] rem_sh;
   logic [14:0] rem_sub;
   logic        q_bit;
   logic [20:0] q_next;
   assign rem_sh  = {rem, dq[20]};
   assign rem_sub = rem_sh[14:0] - divisor;
   assign q_bit   = (rem_sh >= {1'b0, divisor});
   assign q_next  = {dq[19:0], q_bit};

   // Shift first, then add-3 ahead of the next shift; skipped after the last one
   logic [19:0] bcd_sh, bcd_adj;
   assign bcd_sh = {bcd[18:0], bin[15]};
   always_comb begin
      bcd_adj = bcd_sh;
      for (int i = 0; i < 5; i++)
         if (bcd_sh[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
   end

   always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
      if (!Main_RST_n) begin
         ch        <= 1'b0;
         cnt       <= '0;
         divisor   <= '0;
         rem       <= '0;
         dq        <= '0;
         bin       <= '0;
         bcd       <= '0;
         ovr       <= 1'b0;
         inval     <= 1'b0;
         CH1_BCD   <= '0;
         CH2_BCD   <= '0;
         CH1_Ovr   <= 1'b0;
         CH2_Ovr   <= 1'b0;
         CH1_Inval <= 1'b0;
         CH2_Inval <= 1'b0;
         Done      <= 1'b0;
      end else begin
         Done <= store_en & ch;

         if (state == IDLE && start_req) ch <= 1'b0;
         else if (store_en && !ch)       ch <= 1'b1;

         if (load_en || (div_en && cnt == 5'd20)) cnt <= '0;
         else if (div_en || bcd_en)               cnt <= cnt + 5'd1;

         if (load_en) begin
            divisor <= 15'(TimeScale) * 15'(delta);
            rem     <= '0;
            dq      <= DIVIDEND;
         end

         if (div_en) begin
            rem <= q_bit ? rem_sub : rem_sh[14:0];
            dq  <= q_next;
            if (cnt == 5'd20) begin
               bcd <= '0;
               if (divisor == '0) begin
                  bin <= '0; ovr <= 1'b0; inval <= 1'b1;
               end else if (q_next > 21'd65535) begin
                  bin <= 16'hFFFF; ovr <= 1'b1; inval <= 1'b0;
               end else begin
                  bin <= q_next[15:0]; ovr <= 1'b0; inval <= 1'b0;
               end
            end
         end

         if (bcd_en) begin
            bin <= {bin[14:0], 1'b0};
            bcd <= (cnt == 5'd15) ? bcd_sh : bcd_adj;
         end

         if (store_en) begin
            if (!ch) begin
               CH1_BCD <= bcd; CH1_Ovr <= ovr; CH1_Inval <= inval;
            end else begin
               CH2_BCD <= bcd; CH2_Ovr <= ovr; CH2_Inval <= inval;
            end
         end
      end
   end

endmodule

// File: tb/tb_freq_measure_scheduler.sv
// Scoreboard bench for freq_measure_scheduler: stimulus pushes reference results,
// a negedge monitor pops and compares whenever Done is seen.
module tb_freq_measure_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  ts = '0;
   logic [8:0]  r1 = '0, l1 = '0, r2 = '0, l2 = '0;
   logic [19:0] ch1_bcd, ch2_bcd;
   logic        ch1_ovr, ch2_ovr, ch1_inval, ch2_inval, busy, done;

   freq_measure_scheduler dut (
      .Main_CLK(clk), .Main_RST_n(rst_n), .Start(start), .TimeScale(ts),
      .CH1_Right_Time_Cursor(r1), .CH1_Left_Time_Cursor(l1),
      .CH2_Right_Time_Cursor(r2), .CH2_Left_Time_Cursor(l2),
      .CH1_BCD(ch1_bcd), .CH2_BCD(ch2_bcd), .CH1_Ovr(ch1_ovr), .CH2_Ovr(ch2_ovr),
      .CH1_Inval(ch1_inval), .CH2_Inval(ch2_inval), .Busy(busy), .Done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [19:0] b1; logic o1; logic i1;
      logic [19:0] b2; logic o2; logic i2;
      int          dcyc;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r = '0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Reference: frequency = 1474560 / (TimeScale * |R-L|), saturated at 65535
   task automatic model(input int t, input int r, input int l,
                        output logic [19:0] b, output logic o, output logic iv);
      int d, q;
      d = t * ((r > l) ? r - l : l - r);
      if (d == 0) begin
         b = '0; o = 1'b0; iv = 1'b1;
      end else begin
         q  = 1474560 / d;
         o  = (q > 65535);
         iv = 1'b0;
         b  = to_bcd(o ? 65535 : q);
      end
   endtask

   exp_t got;
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            got = sbq.pop_front();
            chk("done_cycle", 32'(cyc), 32'(got.dcyc));
            chk("ch1_bcd",    32'(ch1_bcd),   32'(got.b1));
            chk("ch1_ovr",    32'(ch1_ovr),   32'(got.o1));
            chk("ch1_inval",  32'(ch1_inval), 32'(got.i1));
            chk("ch2_bcd",    32'(ch2_bcd),   32'(got.b2));
            chk("ch2_ovr",    32'(ch2_ovr),   32'(got.o2));
            chk("ch2_inval",  32'(ch2_inval), 32'(got.i2));
            chk("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ch1_bcd"}, 32'(ch1_bcd), 32'd0);
      chk({tag, "_ch2_bcd"}, 32'(ch2_bcd), 32'd0);
      chk({tag, "_flags"}, 32'({ch1_ovr, ch2_ovr, ch1_inval, ch2_inval}), 32'd0);
      chk({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
   endtask

   // mode 0: plain, 1: cursor change + ignored re-Start mid-sequence, 2: reset mid-sequence
   task automatic run(input int t, input int a1, input int b1, input int a2, input int b2,
                      input int mode);
      exp_t e;
      int   n, w;
      @(negedge clk);
      ts = 6'(t); r1 = 9'(a1); l1 = 9'(b1); r2 = 9'(a2); l2 = 9'(b2);
      start = 1'b1;
      @(posedge clk); #1;
      n = cyc;
      model(t, a1, b1, e.b1, e.o1, e.i1);
      model(t, a2, b2, e.b2, e.o2, e.i2);
      e.dcyc = n + 78;
      sbq.push_back(e);
      chk("busy_after_start", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
      if (mode == 1) begin
         while (cyc < n + 10) @(negedge clk);
         r1 = 9'($urandom_range(0, 511)); l1 = 9'($urandom_range(0, 511));
         while (cyc < n + 19) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      if (mode == 2) begin
         while (cyc < n + 49) @(negedge clk);
         rst_n = 1'b0;
         #1;
         sbq.delete();
         check_reset_outputs("midreset");
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end
      w = 0;
      while (sbq.size() != 0 && w < 150) begin
         @(negedge clk);
         w++;
      end
      if (sbq.size() != 0) begin
         chk("done_timeout", 32'(sbq.size()), 32'd0);
         sbq.delete();
      end
   endtask

   initial begin
      #3;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("post_reset_idle");

      run(4, 100, 40, 80, 200, 0);    // basic: 06144 / 03072
      run(1, 10, 0, 23, 0, 0);        // CH1 saturates, CH2 64111
      run(5, 77, 77, 300, 100, 0);    // CH1 zero distance
      run(0, 100, 40, 80, 200, 0);    // zero TimeScale: both invalid
      run(4, 100, 40, 80, 200, 1);    // snapshot + ignored Start
      repeat (100) @(negedge clk);    // any queued re-Start would surface here
      run(3, 250, 10, 5, 400, 2);     // reset at cycle 50
      run(4, 100, 40, 80, 200, 0);
      run(63, 511, 0, 0, 1, 0);       // largest divisor / saturation edge
      for (int k = 0; k < 20; k++) begin
         int a, b;
         a = $urandom_range(0, 511);
         b = (k % 5 == 0) ? a : $urandom_range(0, 511);
         run($urandom_range(0, 63), a, b, $urandom_range(0, 511), $urandom_range(0, 511), 0);
      end
      repeat (100) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
